// File: rtl/palette_lut.sv
// 256-entry CPU-writable palette: 8-bit colour index -> 12-bit RGB, with sync/blank
// qualifiers delayed to match. A greyscale ramp is loaded after every reset.
module palette_lut #(
  parameter int unsigned PIPE_LAT     = 2,
  parameter int unsigned INIT_ENTRIES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  regs_addr,
  input  logic [7:0]  regs_wrdata,
  output logic [7:0]  regs_rddata,
  output logic        regs_rdvalid,
  input  logic        regs_strobe,
  input  logic        regs_write,
  output logic        busy,
  input  logic [7:0]  pix_index,
  input  logic        pix_valid,
  input  logic        pix_blank,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [11:0] rgb_out,
  output logic        rgb_valid,
  output logic        hsync_out,
  output logic        vsync_out
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  localparam logic [7:0] LAST_ENTRY = 8'(INIT_ENTRIES - 1);

  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  // Byte lanes per entry: lo = {G,B}, hi = R.
  logic [7:0] lo_mem [256];
  logic [3:0] hi_mem [256];

  logic       lo_we, hi_we;
  logic [7:0] we_entry;
  logic [7:0] lo_wdata;
  logic [3:0] hi_wdata;
  logic [7:0] cpu_entry;

  logic       rdvalid_q;
  logic [7:0] rddata_q;

  logic [11:0]         s1_rgb_q;
  logic                s1_blank_q;
  logic [PIPE_LAT-1:0] vld_q, hs_q, vs_q;
  logic [11:0]         rgb_q;

  assign cpu_entry = regs_addr[8:1];
  assign busy      = (state_q == ST_INIT);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lo_we    = 1'b0;
    hi_we    = 1'b0;
    we_entry = cpu_entry;
    lo_wdata = regs_wrdata;
    hi_wdata = regs_wrdata[3:0];
    case (state_q)
      ST_INIT: begin
        lo_we    = 1'b1;
        hi_we    = 1'b1;
        we_entry = cnt_q;
        lo_wdata = {cnt_q[7:4], cnt_q[7:4]};
        hi_wdata = cnt_q[7:4];
        if (cnt_q == LAST_ENTRY) state_d = ST_RUN;
        else                     cnt_d   = cnt_q + 8'd1;
      end
      ST_RUN: begin
        if (regs_strobe && regs_write) begin
          lo_we = ~regs_addr[0];
          hi_we = regs_addr[0];
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (lo_we) lo_mem[we_entry] <= lo_wdata;
    if (hi_we) hi_mem[we_entry] <= hi_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdvalid_q <= 1'b0;
      rddata_q  <= '0;
    end else begin
      rdvalid_q <= regs_strobe && !regs_write;
      if (regs_strobe && !regs_write) begin
        if (busy)              rddata_q <= '0;
        else if (regs_addr[0]) rddata_q <= {4'h0, hi_mem[cpu_entry]};
        else                   rddata_q <= lo_mem[cpu_entry];
      end
    end
  end

  // Stage 1 also zeroes its sample while busy so no half-initialised entry leaks into RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_rgb_q   <= '0;
      s1_blank_q <= 1'b0;
      vld_q      <= '0;
      hs_q       <= '0;
      vs_q       <= '0;
      rgb_q      <= '0;
    end else begin
      s1_rgb_q   <= busy ? '0 : {hi_mem[pix_index], lo_mem[pix_index]};
      s1_blank_q <= pix_blank;
      vld_q      <= {vld_q[PIPE_LAT-2:0], pix_valid};
      hs_q       <= {hs_q[PIPE_LAT-2:0], hsync_in};
      vs_q       <= {vs_q[PIPE_LAT-2:0], vsync_in};
      if (busy)          rgb_q <= '0;
      else if (vld_q[0]) rgb_q <= s1_blank_q ? '0 : s1_rgb_q;
    end
  end

  assign regs_rdvalid = rdvalid_q;
  assign regs_rddata  = rddata_q;
  assign rgb_out      = rgb_q;
  assign rgb_valid    = vld_q[PIPE_LAT-1];
  assign hsync_out    = hs_q[PIPE_LAT-1];
  assign vsync_out    = vs_q[PIPE_LAT-1];

endmodule
